gmii_rx_buffer: RTL and testbench

//  Receive-side rate adapter between the 10/100M MAC/PHY port and the byte-wide GMII RX path.
//  - In 10/100M mode: rebuilds bytes from nibble pairs (low nibble first) and stores whole frames.
//  - Replays each stored frame to GMII as a contiguous one-byte-per-clock burst.
//  - In 1000M mode: registered pass-through.

---
 rtl/gmii_rx_buffer.sv | 234 +++++++++++++++++++++++
 tb/tb_gmii_rx_buffer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_rx_buffer.sv
// Receive rate adapter: assembles 10/100M nibbles into whole frames and replays each frame
// to GMII as a contiguous byte burst; 1000M mode is a registered pass-through.
module gmii_rx_buffer #(
   parameter int unsigned DATA_AW = 11,
   parameter int unsigned LEN_AW  = 4,
   parameter int unsigned IFG     = 12
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       eth_10_100m_en,
   input  logic       link,
   input  logic       e10_100_rx_dv,
   input  logic [7:0] e10_100_rxd,
   output logic       gmii_rx_dv,
   output logic [7:0] gmii_rxd
);

   localparam int unsigned DataDepth = 2 ** DATA_AW;
   localparam int unsigned LenDepth  = 2 ** LEN_AW;
   localparam int unsigned DPW       = DATA_AW + 1;
   localparam int unsigned LPW       = LEN_AW + 1;
   localparam int unsigned GapW      = (IFG > 1) ? $clog2(IFG) : 1;
   localparam logic [GapW-1:0] GapLast = GapW'(IFG - 1);

   typedef enum logic [1:0] {StIdle, StLenLatch, StSend, StGap} state_e;

   logic [7:0]  data_mem [DataDepth];
   logic [15:0] len_mem  [LenDepth];

   state_e          state_q, state_d;
   logic            phase_q, phase_d;
   logic [3:0]      low_q, low_d;
   logic            rx_dv_d0_q, rx_dv_d0_d;
   logic [15:0]     frame_len_q, frame_len_d;
   logic            ovf_q, ovf_d;
   logic [DPW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [DPW-1:0]  frm_start_q, frm_start_d;
   logic [DPW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [LPW-1:0]  lwr_ptr_q, lwr_ptr_d;
   logic [LPW-1:0]  lrd_ptr_q, lrd_ptr_d;
   logic [15:0]     rd_cnt_q, rd_cnt_d;
   logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
   logic            rd_vld_q, rd_vld_d;
   logic [7:0]      rd_data_q, rd_data_d;
   logic            gmii_rx_dv_q, gmii_rx_dv_d;
   logic [7:0]      gmii_rxd_q, gmii_rxd_d;

   logic           flush;
   logic           data_full;
   logic           len_full;
   logic           len_empty;
   logic           byte_vld;
   logic           data_we;
   logic           frame_end;
   logic           commit;
   logic           len_we;
   logic [DPW-1:0] wr_base;
   logic           len_pop;
   logic           rd_en;

   assign flush     = !link || !eth_10_100m_en;
   assign data_full = (wr_ptr_q[DATA_AW] != rd_ptr_q[DATA_AW]) &&
                      (wr_ptr_q[DATA_AW-1:0] == rd_ptr_q[DATA_AW-1:0]);
   assign len_full  = (lwr_ptr_q[LEN_AW] != lrd_ptr_q[LEN_AW]) &&
                      (lwr_ptr_q[LEN_AW-1:0] == lrd_ptr_q[LEN_AW-1:0]);
   assign len_empty = (lwr_ptr_q == lrd_ptr_q);

   assign byte_vld  = e10_100_rx_dv && phase_q;
   assign data_we   = byte_vld && !data_full && !flush;
   assign frame_end = rx_dv_d0_q && !e10_100_rx_dv;
   assign commit    = frame_end && (frame_len_q != 16'd0) && !ovf_q && !len_full;
   assign len_we    = commit && !flush;
   // A dropped frame rewinds the write pointer; any same-cycle byte lands after the rewind.
   assign wr_base   = (frame_end && !commit) ? frm_start_q : wr_ptr_q;

   // Write side: nibble assembly, frame commit/drop and overflow tracking.
   always_comb begin
      phase_d     = e10_100_rx_dv ? !phase_q : 1'b0;
      low_d       = low_q;
      rx_dv_d0_d  = e10_100_rx_dv;
      frame_len_d = frame_len_q;
      ovf_d       = ovf_q;
      frm_start_d = frm_start_q;
      lwr_ptr_d   = lwr_ptr_q;
      wr_ptr_d    = wr_base + DPW'(data_we);

      if (e10_100_rx_dv && !phase_q) begin
         low_d = e10_100_rxd[3:0];
      end
      if (frame_end) begin
         frame_len_d = 16'd0;
         ovf_d       = 1'b0;
         if (commit) begin
            lwr_ptr_d   = lwr_ptr_q + LPW'(1);
            frm_start_d = wr_ptr_q;
         end
      end
      if (data_we) begin
         frame_len_d = frame_len_d + 16'd1;
      end else if (byte_vld && data_full) begin
         ovf_d = 1'b1;
      end

      if (flush) begin
         phase_d     = 1'b0;
         low_d       = 4'd0;
         rx_dv_d0_d  = 1'b0;
         frame_len_d = 16'd0;
         ovf_d       = 1'b0;
         frm_start_d = '0;
         lwr_ptr_d   = '0;
         wr_ptr_d    = '0;
      end
   end

   // Read FSM next state.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:     if (!len_empty) state_d = StLenLatch;
         StLenLatch: state_d = StSend;
         StSend:     if (rd_cnt_q == 16'd1) state_d = StGap;
         StGap:      if (gap_cnt_q == GapLast) state_d = StIdle;
         default:    state_d = StIdle;
      endcase
      if (flush) begin
         state_d = StIdle;
      end
   end

   // Read FSM outputs.
   always_comb begin
      len_pop = (state_q == StLenLatch);
      rd_en   = (state_q == StSend);
   end

   // Read-side counters, pointers and the registered memory read.
   always_comb begin
      rd_ptr_d  = rd_ptr_q;
      lrd_ptr_d = lrd_ptr_q;
      rd_cnt_d  = rd_cnt_q;
      gap_cnt_d = gap_cnt_q;
      rd_data_d = rd_data_q;
      rd_vld_d  = rd_en && !flush;

      if (len_pop) begin
         rd_cnt_d  = len_mem[lrd_ptr_q[LEN_AW-1:0]];
         lrd_ptr_d = lrd_ptr_q + LPW'(1);
      end
      if (rd_en) begin
         rd_data_d = data_mem[rd_ptr_q[DATA_AW-1:0]];
         rd_ptr_d  = rd_ptr_q + DPW'(1);
         rd_cnt_d  = rd_cnt_q - 16'd1;
         gap_cnt_d = '0;
      end
      if (state_q == StGap) begin
         gap_cnt_d = gap_cnt_q + GapW'(1);
      end

      if (flush) begin
         rd_ptr_d  = '0;
         lrd_ptr_d = '0;
         rd_cnt_d  = 16'd0;
         gap_cnt_d = '0;
      end
   end

   // Buffer path is gated off immediately on link loss so dv drops the very next cycle.
   always_comb begin
      if (!eth_10_100m_en) begin
         gmii_rx_dv_d = e10_100_rx_dv;
         gmii_rxd_d   = e10_100_rxd;
      end else if (!link) begin
         gmii_rx_dv_d = 1'b0;
         gmii_rxd_d   = 8'd0;
      end else begin
         gmii_rx_dv_d = rd_vld_q;
         gmii_rxd_d   = rd_vld_q ? rd_data_q : 8'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (data_we) begin
         data_mem[wr_base[DATA_AW-1:0]] <= {e10_100_rxd[3:0], low_q};
      end
      if (len_we) begin
         len_mem[lwr_ptr_q[LEN_AW-1:0]] <= frame_len_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         phase_q      <= 1'b0;
         low_q        <= 4'd0;
         rx_dv_d0_q   <= 1'b0;
         frame_len_q  <= 16'd0;
         ovf_q        <= 1'b0;
         wr_ptr_q     <= '0;
         frm_start_q  <= '0;
         rd_ptr_q     <= '0;
         lwr_ptr_q    <= '0;
         lrd_ptr_q    <= '0;
         rd_cnt_q     <= 16'd0;
         gap_cnt_q    <= '0;
         rd_vld_q     <= 1'b0;
         rd_data_q    <= 8'd0;
         gmii_rx_dv_q <= 1'b0;
         gmii_rxd_q   <= 8'd0;
      end else begin
         state_q      <= state_d;
         phase_q      <= phase_d;
         low_q        <= low_d;
         rx_dv_d0_q   <= rx_dv_d0_d;
         frame_len_q  <= frame_len_d;
         ovf_q        <= ovf_d;
         wr_ptr_q     <= wr_ptr_d;
         frm_start_q  <= frm_start_d;
         rd_ptr_q     <= rd_ptr_d;
         lwr_ptr_q    <= lwr_ptr_d;
         lrd_ptr_q    <= lrd_ptr_d;
         rd_cnt_q     <= rd_cnt_d;
         gap_cnt_q    <= gap_cnt_d;
         rd_vld_q     <= rd_vld_d;
         rd_data_q    <= rd_data_d;
         gmii_rx_dv_q <= gmii_rx_dv_d;
         gmii_rxd_q   <= gmii_rxd_d;
      end
   end

   assign gmii_rx_dv = gmii_rx_dv_q;
   assign gmii_rxd   = gmii_rxd_q;

endmodule

// File: tb/tb_gmii_rx_buffer.sv
// Scoreboard bench for gmii_rx_buffer: a default-size instance plus a 16-byte instance
// used for the overflow case.
module tb_gmii_rx_buffer;

   localparam int IFG = 12;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b1;
   logic       en_s = 1'b1;
   logic       link = 1'b1;
   logic       link_s = 1'b0;
   logic       rx_dv = 1'b0;
   logic [7:0] rxd = 8'd0;
   logic [1:0] dv_w;
   logic [7:0] rxd_w [2];

   logic [7:0] exp_q [2][$];
   int         len_q [2][$];
   logic [7:0] pat [$];
   logic [1:0] mon_en = 2'b11;
   int         run_len [2];
   int         low_len [2];
   int         seen [2];
   int         bytes_seen [2];
   int         total = 0;
   int         bad = 0;

   always #5 clk = ~clk;

   gmii_rx_buffer #(.DATA_AW(11), .LEN_AW(4), .IFG(IFG)) u_dut (
      .clk(clk), .rst_n(rst_n), .eth_10_100m_en(en), .link(link),
      .e10_100_rx_dv(rx_dv), .e10_100_rxd(rxd),
      .gmii_rx_dv(dv_w[0]), .gmii_rxd(rxd_w[0])
   );

   gmii_rx_buffer #(.DATA_AW(4), .LEN_AW(4), .IFG(IFG)) u_small (
      .clk(clk), .rst_n(rst_n), .eth_10_100m_en(en_s), .link(link_s),
      .e10_100_rx_dv(rx_dv), .e10_100_rxd(rxd),
      .gmii_rx_dv(dv_w[1]), .gmii_rxd(rxd_w[1])
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Output monitor: byte values, frame lengths (contiguity) and inter-frame gap.
   initial begin
      logic [7:0] eb;
      int el;
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < 2; i++) begin
            if (!rst_n || !mon_en[i]) begin
               run_len[i] = 0;
               low_len[i] = 0;
               seen[i] = 0;
            end else if (dv_w[i]) begin
               bytes_seen[i]++;
               if (run_len[i] == 0 && seen[i] != 0) chk("ifg", 32'(low_len[i] >= IFG), 1);
               if (exp_q[i].size() == 0) begin
                  chk("extra_dv", 32'(dv_w[i]), 0);
               end else begin
                  eb = exp_q[i].pop_front();
                  chk("byte", 32'(rxd_w[i]), 32'(eb));
               end
               run_len[i]++;
               low_len[i] = 0;
            end else begin
               chk("idle_rxd", 32'(rxd_w[i]), 0);
               if (run_len[i] > 0) begin
                  if (len_q[i].size() == 0) begin
                     chk("extra_frame", run_len[i], 0);
                  end else begin
                     el = len_q[i].pop_front();
                     chk("frame_len", run_len[i], el);
                  end
                  seen[i] = 1;
                  run_len[i] = 0;
               end
               low_len[i]++;
            end
         end
      end
   end

   task automatic drive_nib(input logic [3:0] n);
      logic [3:0] hi;
      @(negedge clk);
      hi = 4'($urandom);
      rx_dv = 1'b1;
      rxd = {hi, n};
   endtask

   // Bytes come from pat (then random); expectations are queued before driving.
   task automatic send_frame(input int nbytes, input bit odd, input int gap,
                             input bit to0, input bit to1);
      logic [7:0] bq [$];
      logic [7:0] b;
      for (int i = 0; i < nbytes; i++) begin
         b = (i < pat.size()) ? pat[i] : 8'($urandom);
         bq.push_back(b);
         if (to0) exp_q[0].push_back(b);
         if (to1) exp_q[1].push_back(b);
      end
      if (nbytes > 0 && to0) len_q[0].push_back(nbytes);
      if (nbytes > 0 && to1) len_q[1].push_back(nbytes);
      pat.delete();
      foreach (bq[i]) begin
         b = bq[i];
         drive_nib(b[3:0]);
         drive_nib(b[7:4]);
      end
      if (odd) drive_nib(4'($urandom));
      @(negedge clk);
      rx_dv = 1'b0;
      rxd = 8'd0;
      repeat (gap - 1) @(negedge clk);
   endtask

   task automatic drain();
      int k;
      for (k = 0; k < 5000; k++) begin
         @(negedge clk);
         if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && len_q[0].size() == 0 &&
             len_q[1].size() == 0 && dv_w == 2'b00) break;
      end
      chk("drain_timeout", 32'(k < 5000), 1);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int base;
      int k;
      #2;
      chk("rst_dv", 32'(dv_w[0]), 0);
      chk("rst_rxd", 32'(rxd_w[0]), 0);
      chk("rst_dv_s", 32'(dv_w[1]), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Nibble order: low nibble first.
      pat = '{8'h55, 8'hD5, 8'h12, 8'hAB};
      send_frame(4, 1'b0, 4, 1'b1, 1'b0);
      drain();

      // Trailing odd nibble dropped; a lone nibble yields no frame.
      pat = '{8'h34, 8'h34, 8'h34};
      send_frame(3, 1'b1, 4, 1'b1, 1'b0);
      send_frame(0, 1'b1, 4, 1'b1, 1'b0);
      drain();

      // Back-to-back frames with a single idle cycle between them.
      send_frame(60, 1'b0, 1, 1'b1, 1'b0);
      send_frame(64, 1'b0, 4, 1'b1, 1'b0);
      drain();

      // Small instance: 20-byte frame overflows 16 bytes and is dropped.
      @(negedge clk);
      link_s = 1'b1;
      repeat (2) @(negedge clk);
      send_frame(20, 1'b0, 20, 1'b1, 1'b0);
      send_frame(4, 1'b0, 4, 1'b1, 1'b1);
      drain();
      link_s = 1'b0;

      // Link loss in the middle of a replay.
      send_frame(64, 1'b0, 5, 1'b1, 1'b0);
      base = bytes_seen[0];
      for (k = 0; k < 3000 && bytes_seen[0] < base + 10; k++) @(negedge clk);
      chk("wait_send", 32'(bytes_seen[0] >= base + 10), 1);
      mon_en[0] = 1'b0;
      link = 1'b0;
      @(posedge clk);
      #1;
      chk("flush_dv", 32'(dv_w[0]), 0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("flush_hold", 32'(dv_w[0]), 0);
      end
      @(negedge clk);
      exp_q[0].delete();
      len_q[0].delete();
      link = 1'b1;
      mon_en[0] = 1'b1;
      repeat (2) @(negedge clk);
      send_frame(4, 1'b0, 4, 1'b1, 1'b0);
      drain();

      // 1000M pass-through.
      mon_en[0] = 1'b0;
      en = 1'b0;
      rx_dv = 1'b1;
      rxd = 8'hA5;
      @(posedge clk);
      #1;
      chk("byp_dv", 32'(dv_w[0]), 1);
      chk("byp_rxd", 32'(rxd_w[0]), 32'h A5);
      @(negedge clk);
      rx_dv = 1'b0;
      rxd = 8'h3C;
      @(posedge clk);
      #1;
      chk("byp_dv0", 32'(dv_w[0]), 0);
      chk("byp_rxd2", 32'(rxd_w[0]), 32'h3C);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #600000;
      bad++;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
